uart_tx_slave: RTL and testbench

- Memory-mapped UART transmitter; responder on the slave side of the MemoryBus, occupying a 4-word window behind the slave bus mux.
- CPU or probe writes bytes into a TX FIFO. An 8N1 shifter serializes them onto tx_o at a programmable baud divisor.
- Status and divisor registers are readable so firmware can poll before writing.

---
 rtl/uart_tx_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_tx_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_slave.sv
// -----------------------------------------------------------------------------
// uart_tx_slave
// Memory-mapped UART transmitter sitting behind the slave bus mux. Firmware
// pushes bytes into a TX FIFO; a shifter serializes them onto tx_o as 8N1
// frames (8E1/8O1 when parity is built in) at a programmable baud divisor.
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, a parity bit is sent between the last
//                        data bit and the stop bit. CTRL bit1 selects odd
//                        parity, and STATUS bit8 reads 1.
//
// Register map (cmd.address[1:0]; upper address bits are ignored):
//   0 DATA   W: push write_data[7:0] when mask_byte[0]. Reads 0.
//   1 STATUS R: {bit8 parity_built, [7:4] level (sat 15), 3 overflow,
//               2 busy, 1 empty, 0 full}
//   2 DIV    R/W: clk cycles per bit; write needs mask_byte[1:0]=2'b11,
//               values below 2 are clamped to 2.
//   3 CTRL   W: bit0=1 flushes FIFO and clears overflow (mask_byte[0]).
//               bit1 odd-parity select when parity is built in.
//
// Bus handshake: there is no valid/ready pair. A write is accepted on every
// rising clk edge where cmd.mem_write=1 (no wait states); a read is answered
// combinationally in the same cycle as cmd.mem_read, result is 0 otherwise.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   cmd         bus command (address, mem_read, mem_write, mask_byte,
//               write_data)
//   result      read data
//   tx_o        serial line, idle high
//   irq_o       high when FIFO empty and shifter idle
//   busy_o      shifter active or FIFO non-empty
//   o_dbg_state current shifter FSM state (debug observation)
// -----------------------------------------------------------------------------

package MemoryBus;
   typedef struct packed {
      logic [29:0] address;
      logic        mem_read;
      logic        mem_write;
      logic [3:0]  mask_byte;
      logic [31:0] write_data;
   } Cmd;

   typedef struct packed {
      logic [31:0] read_data;
   } Result;
endpackage

module uart_tx_slave #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 434
) (
   input  logic             clk,
   input  logic             rst,
   input  MemoryBus::Cmd    cmd,
   output MemoryBus::Result result,
   output logic             tx_o,
   output logic             irq_o,
   output logic             busy_o,
   output logic [2:0]       o_dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } state_t;
   localparam logic PARITY_BUILT = 1'b1;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3
   } state_t;
   localparam logic PARITY_BUILT = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic [1:0]           w_addr;
   logic                 w_push_req;
   logic                 w_push;
   logic                 w_flush;
   logic                 w_ctrl_wr;
   logic                 w_div_wr;
   logic [DIV_WIDTH-1:0] w_div_wdata;
   logic                 w_unused;

   assign w_addr      = cmd.address[1:0];
   assign w_push_req  = cmd.mem_write && (w_addr == 2'd0) && cmd.mask_byte[0];
   assign w_ctrl_wr   = cmd.mem_write && (w_addr == 2'd3) && cmd.mask_byte[0];
   assign w_flush     = w_ctrl_wr && cmd.write_data[0];
   assign w_div_wr    = cmd.mem_write && (w_addr == 2'd2) && (cmd.mask_byte[1:0] == 2'b11);
   assign w_div_wdata = cmd.write_data[DIV_WIDTH-1:0];
   // Upper address/data/mask bits are intentionally not decoded.
   assign w_unused    = ^cmd;

   // ---------------------------------------------------------------------
   // TX FIFO: pointers carry one extra wrap bit so full and empty can be
   // told apart when the index bits match.
   // ---------------------------------------------------------------------
   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic [AW:0] w_level;
   logic        w_empty;
   logic        w_full;
   logic [7:0]  w_head;
   logic        w_pop;
   logic        r_overflow;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   // A full FIFO still accepts a push when the shifter pops in the same cycle.
   assign w_push = w_push_req && (!w_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (w_flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !w_flush) r_mem[r_wr_ptr[AW-1:0]] <= cmd.write_data[7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_overflow <= 1'b0;
      else if (w_flush)                 r_overflow <= 1'b0;
      else if (w_push_req && !w_push)   r_overflow <= 1'b1;
   end

   // ---------------------------------------------------------------------
   // Divisor register
   // ---------------------------------------------------------------------
   logic [DIV_WIDTH-1:0] r_div;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_div <= DIV_RST;
      else if (w_div_wr) r_div <= (w_div_wdata < DIV_MIN) ? DIV_MIN : w_div_wdata;
   end

   // ---------------------------------------------------------------------
   // Parity control
   // ---------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
   logic r_odd;
   logic r_par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_odd <= 1'b0;
      else if (w_ctrl_wr) r_odd <= cmd.write_data[1];
   end

   // Parity is fixed when the byte leaves the FIFO, alongside the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_par <= 1'b0;
      else if (w_pop) r_par <= (^w_head) ^ r_odd;
   end
`endif

   // ---------------------------------------------------------------------
   // Shifter FSM
   // ---------------------------------------------------------------------
   state_t               r_state;
   state_t               w_state_next;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [DIV_WIDTH-1:0] w_cnt_next;
   logic [DIV_WIDTH-1:0] r_frame_div;
   logic [DIV_WIDTH-1:0] w_frame_div_next;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_next;
   logic [7:0]           r_shift;
   logic [7:0]           w_shift_next;
   logic                 r_tx;
   logic                 w_tx_next;
   logic                 w_bit_end;
   logic                 w_can_pop;

   assign w_bit_end = (r_cnt == (r_frame_div - CNT_ONE));
   // A flush in the same cycle wins over starting a new frame.
   assign w_can_pop = !w_empty && !w_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_frame_div <= DIV_RST;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_tx        <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_frame_div <= w_frame_div_next;
         r_bit_idx   <= w_bit_idx_next;
         r_shift     <= w_shift_next;
         r_tx        <= w_tx_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_frame_div_next = r_frame_div;
      w_bit_idx_next   = r_bit_idx;
      w_shift_next     = r_shift;
      w_pop            = 1'b0;
      w_tx_next        = 1'b1;

      unique case (r_state)
         ST_IDLE: begin
            if (w_can_pop) begin
               w_pop            = 1'b1;
               w_shift_next     = w_head;
               w_frame_div_next = r_div;
               w_cnt_next       = '0;
               w_state_next     = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_end) begin
               w_cnt_next     = '0;
               w_bit_idx_next = 3'd0;
               w_state_next   = ST_DATA;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_cnt_next = '0;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = ST_PARITY;
`else
                  w_state_next = ST_STOP;
`endif
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
                  w_shift_next   = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_end) begin
               w_cnt_next   = '0;
               w_state_next = ST_STOP;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_end) begin
               w_cnt_next = '0;
               // Back-to-back frames: next start bit follows the stop bit
               // with no idle gap.
               if (w_can_pop) begin
                  w_pop            = 1'b1;
                  w_shift_next     = w_head;
                  w_frame_div_next = r_div;
                  w_state_next     = ST_START;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Line level is registered from the next state so tx_o is glitch-free.
      unique case (w_state_next)
         ST_START:  w_tx_next = 1'b0;
         ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_next = r_par;
`endif
         default:   w_tx_next = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------
   // Derived outputs and read path
   // ---------------------------------------------------------------------
   logic [31:0] w_level_ext;
   logic [3:0]  w_level_sat;
   logic [31:0] w_status;
   logic [31:0] w_ctrl_rd;

   assign w_level_ext = 32'(w_level);
   assign w_level_sat = (w_level_ext > 32'd15) ? 4'hF : w_level_ext[3:0];

   assign busy_o      = (r_state != ST_IDLE) || !w_empty;
   assign irq_o       = !busy_o;
   assign tx_o        = r_tx;
   assign o_dbg_state = r_state;

   assign w_status = {23'd0, PARITY_BUILT, w_level_sat, r_overflow, busy_o,
                      w_empty, w_full};

`ifdef UART_TX_PARITY_EN
   assign w_ctrl_rd = {30'd0, r_odd, 1'b0};
`else
   assign w_ctrl_rd = 32'd0;
`endif

   always_comb begin
      result = '0;
      if (cmd.mem_read) begin
         unique case (w_addr)
            2'd1:    result.read_data = w_status;
            2'd2:    result.read_data = 32'(r_div);
            2'd3:    result.read_data = w_ctrl_rd;
            default: result.read_data = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_slave.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_slave
// Bench for uart_tx_slave. Pushed bytes are queued with the divisor and parity
// mode that should apply to their frame; a line monitor checks every cycle of
// each frame against that entry and recovers the byte at mid-bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_slave;

`ifdef UART_TX_PARITY_EN
   localparam int          NB = 11;
   localparam logic [31:0] PS = 32'h100;
`else
   localparam int          NB = 10;
   localparam logic [31:0] PS = 32'h000;
`endif

   // clock / reset
   logic             clk;
   logic             rst;
   MemoryBus::Cmd    cmd;
   MemoryBus::Result result;
   logic             tx_o;
   logic             irq_o;
   logic             busy_o;
   logic [2:0]       o_dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_slave #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .DEFAULT_DIV(434)) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd),
      .result      (result),
      .tx_o        (tx_o),
      .irq_o       (irq_o),
      .busy_o      (busy_o),
      .o_dbg_state (o_dbg_state)
   );

   // scoreboard: {odd, div[15:0], data[7:0]}
   logic [24:0] exp_q[$];
   int          frame_starts[$];
   int          n_frames = 0;
   bit          mon_en   = 1'b1;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk);
      cmd.address    = {28'd0, a};
      cmd.write_data = d;
      cmd.mask_byte  = m;
      cmd.mem_write  = 1'b1;
      @(posedge clk);
      #1;
      cmd.mem_write  = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      cmd.address  = {28'd0, a};
      cmd.mem_read = 1'b1;
      #1;
      d = result.read_data;
      cmd.mem_read = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, input logic [15:0] dv, input logic odd, input bit expect_tx);
      if (expect_tx) exp_q.push_back({odd, dv, b});
      bus_write(2'd0, {24'd0, b}, 4'b0001);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (busy_o !== 1'b0 && k < lim) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("wait_idle", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic wait_frames(input int target, input int lim);
      int k = 0;
      while (n_frames < target && k < lim) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_eq("wait_frames", n_frames, target);
   endtask

   // line monitor
   initial begin
      logic [24:0] ent;
      logic [10:0] bits;
      logic [10:0] rx_bits;
      int          dv;
      int          err;
      int          berr;
      forever begin
         @(negedge clk);
         if (mon_en && rst === 1'b0 && tx_o === 1'b0) begin
            if (exp_q.size() == 0) begin
               check_eq("frame_expected", exp_q.size(), 1);
               for (int k = 0; k < 5000 && tx_o === 1'b0; k++) @(negedge clk);
            end else begin
               ent = exp_q.pop_front();
               frame_starts.push_back(cyc);
               n_frames++;
               dv   = int'(ent[23:8]);
               bits = '1;
               bits[0]   = 1'b0;
               bits[8:1] = ent[7:0];
`ifdef UART_TX_PARITY_EN
               bits[9] = (^ent[7:0]) ^ ent[24];
`endif
               rx_bits = '1;
               err  = 0;
               berr = 0;
               for (int i = 0; i < NB * dv; i++) begin
                  if (i > 0) @(negedge clk);
                  if (tx_o !== bits[i / dv]) err++;
                  if (busy_o !== 1'b1) berr++;
                  if ((i % dv) == (dv / 2)) rx_bits[i / dv] = tx_o;
               end
               check_eq("frame_wave_errs", err, 0);
               check_eq("frame_busy_errs", berr, 0);
               check_eq("rx_byte", {24'd0, rx_bits[8:1]}, {24'd0, ent[7:0]});
            end
         end
      end
   end

   // watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // main sequence
   initial begin
      logic [31:0] rd;
      int          f0;
      int          nf;

      cmd = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx", {31'd0, tx_o}, 32'd1);
      check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("rst_irq", {31'd0, irq_o}, 32'd1);
      check_eq("rst_state", {29'd0, o_dbg_state}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      bus_read(2'd1, rd);
      check_eq("rst_status", rd, PS | 32'h02);
      bus_read(2'd2, rd);
      check_eq("rst_div", rd, 32'd434);
      bus_read(2'd0, rd);
      check_eq("data_reads_zero", rd, 32'd0);
      #1;
      check_eq("result_idle_zero", result.read_data, 32'd0);

      // --- single frame, DIV=4, 0x55, exact start latency ---
      bus_write(2'd2, 32'd4, 4'b0011);
      bus_read(2'd2, rd);
      check_eq("div_4", rd, 32'd4);
      exp_q.push_back({1'b0, 16'd4, 8'h55});
      @(negedge clk);
      cmd.address    = 30'd0;
      cmd.write_data = 32'h55;
      cmd.mask_byte  = 4'b0001;
      cmd.mem_write  = 1'b1;
      @(posedge clk);
      #1;
      cmd.mem_write = 1'b0;
      check_eq("tx_before_start", {31'd0, tx_o}, 32'd1);
      check_eq("busy_after_push", {31'd0, busy_o}, 32'd1);
      @(posedge clk);
      #1;
      check_eq("tx_start_latency", {31'd0, tx_o}, 32'd0);
      repeat (NB * 4 - 1) @(posedge clk);
      #1;
      check_eq("busy_last_stop_cycle", {31'd0, busy_o}, 32'd1);
      check_eq("irq_last_stop_cycle", {31'd0, irq_o}, 32'd0);
      @(posedge clk);
      #1;
      check_eq("irq_after_stop", {31'd0, irq_o}, 32'd1);

      // --- back-to-back frames, DIV=2, level 2->1->0 ---
      bus_write(2'd2, 32'd2, 4'b0011);
      f0 = n_frames;
      push_byte(8'hA5, 16'd2, 1'b0, 1'b1);
      push_byte(8'h3C, 16'd2, 1'b0, 1'b1);
      push_byte(8'hF0, 16'd2, 1'b0, 1'b1);
      bus_read(2'd1, rd);
      check_eq("status_level2", rd, PS | 32'h24);
      wait_frames(f0 + 2, 200);
      bus_read(2'd1, rd);
      check_eq("status_level1", rd, PS | 32'h14);
      wait_frames(f0 + 3, 200);
      bus_read(2'd1, rd);
      check_eq("status_level0", rd, PS | 32'h06);
      wait_idle(200);
      check_eq("gap_frame1_2", frame_starts[f0 + 1] - frame_starts[f0], NB * 2);
      check_eq("gap_frame2_3", frame_starts[f0 + 2] - frame_starts[f0 + 1], NB * 2);

      // --- overflow: 9 accepted (1 shifting + 8 queued), 10th dropped ---
      for (int i = 0; i < 10; i++)
         push_byte(8'(8'h60 + i * 7), 16'd2, 1'b0, i < 9);
      bus_read(2'd1, rd);
      check_eq("status_full_ovf", rd, PS | 32'h8D);
      wait_idle(1000);
      bus_read(2'd1, rd);
      check_eq("status_ovf_sticky", rd, PS | 32'h0A);

      // --- divisor clamp and mid-frame divisor change ---
      bus_write(2'd2, 32'd0, 4'b0011);
      bus_read(2'd2, rd);
      check_eq("div_clamp0", rd, 32'd2);
      bus_write(2'd2, 32'd1, 4'b0011);
      bus_read(2'd2, rd);
      check_eq("div_clamp1", rd, 32'd2);
      bus_write(2'd2, 32'd9, 4'b0001);
      bus_read(2'd2, rd);
      check_eq("div_partial_mask", rd, 32'd2);
      bus_write(2'd2, 32'd4, 4'b0011);
      nf = n_frames;
      push_byte(8'h81, 16'd4, 1'b0, 1'b1);
      wait_frames(nf + 1, 50);
      bus_write(2'd2, 32'd100, 4'b0011);
      push_byte(8'h42, 16'd100, 1'b0, 1'b1);
      bus_read(2'd2, rd);
      check_eq("div_100", rd, 32'd100);
      wait_idle(3000);

      // --- flush mid-frame with 3 bytes queued (also clears overflow) ---
      bus_write(2'd2, 32'd4, 4'b0011);
      nf = n_frames;
      push_byte(8'h11, 16'd4, 1'b0, 1'b1);
      push_byte(8'h22, 16'd4, 1'b0, 1'b0);
      push_byte(8'h33, 16'd4, 1'b0, 1'b0);
      push_byte(8'h44, 16'd4, 1'b0, 1'b0);
      bus_read(2'd1, rd);
      check_eq("status_pre_flush", rd, PS | 32'h3C);
      repeat (10) @(posedge clk);
      bus_write(2'd3, 32'd1, 4'b0001);
      bus_read(2'd1, rd);
      check_eq("status_post_flush", rd, PS | 32'h06);
      wait_idle(200);
      repeat (60) @(posedge clk);
      check_eq("frames_after_flush", n_frames, nf + 1);
      bus_write(2'd0, 32'h99, 4'b1110);
      bus_read(2'd1, rd);
      check_eq("push_mask_off", rd, PS | 32'h02);

`ifdef UART_TX_PARITY_EN
      // --- parity: 0x07 odd -> parity 0, even -> parity 1 ---
      bus_write(2'd3, 32'd2, 4'b0001);
      bus_read(2'd3, rd);
      check_eq("ctrl_odd_rd", rd, 32'd2);
      push_byte(8'h07, 16'd4, 1'b1, 1'b1);
      wait_idle(200);
      bus_write(2'd3, 32'd0, 4'b0001);
      push_byte(8'h07, 16'd4, 1'b0, 1'b1);
      wait_idle(200);
`endif

      // --- asynchronous reset in the middle of the data bits ---
      mon_en = 1'b0;
      push_byte(8'h00, 16'd4, 1'b0, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      check_eq("tx_mid_data", {31'd0, tx_o}, 32'd0);
      check_eq("state_mid_data", {29'd0, o_dbg_state}, 32'd2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_tx", {31'd0, tx_o}, 32'd1);
      check_eq("async_rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("async_rst_irq", {31'd0, irq_o}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      bus_read(2'd2, rd);
      check_eq("post_rst_div", rd, 32'd434);
      bus_read(2'd1, rd);
      check_eq("post_rst_status", rd, PS | 32'h02);

      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
